serial_subtractor: RTL and testbench

//  - Bit-serial ripple-borrow subtractor: computes a - b - borrow_in one bit per clock, LSB first.
//  - Inverse companion to the ripple-carry adder datapath; trades area for latency.
//  - Used where a WIDTH-bit difference is needed but a parallel subtractor is too large.
//  - start/busy/done handshake; result held stable until the next accepted start.

---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 163 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The optional signed-overflow flag is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ceiling log2, used to size the bit counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = 1;
        while (v < value) begin
            v      = v << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, a - b - borrow_in, LSB first.
// Optional signed overflow output enabled with SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fs_d;
    logic               fs_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               overflow_q, overflow_d;
`endif

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath; busy/done are decoded from the next state so they are registered.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        overflow_d   = overflow_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end

            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = fs_bout;
                res_d  = {fs_d, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d      = DONE;
                    done_d       = 1'b1;
                    diff_d       = {fs_d, res_q[WIDTH-1:1]};
                    borrow_out_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // Final d is the result MSB.
                    overflow_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            overflow_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            overflow_q   <= overflow_d;
`endif
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = overflow_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); covers SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

    localparam int unsigned W    = 4;
    localparam int          MAXS = (1 << (W - 1)) - 1;
    localparam int          MINS = -(1 << (W - 1));

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;
    logic         ovf;

    int n_cmp;
    int n_fail;

    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (ovf)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        int r;
        int sa;
        int sb;
        int s;
        r        = int'(ta) - int'(tb_v) - int'(tbin);
        exp_diff = W'(r & ((1 << W) - 1));
        exp_bout = (int'(ta) < int'(tb_v) + int'(tbin));
        sa       = (int'(ta) > MAXS) ? int'(ta) - (1 << W) : int'(ta);
        sb       = (int'(tb_v) > MAXS) ? int'(tb_v) - (1 << W) : int'(tb_v);
        s        = sa - sb - int'(tbin);
`ifdef SERIAL_SUB_OVF_EN
        exp_ovf  = (s > MAXS) || (s < MINS);
`else
        exp_ovf  = 1'b0;
`endif
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        chk({tag, "_bout"}, 32'(borrow_out), 32'(exp_bout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    // One operation starting in IDLE; noisy drives start and new operands while busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input bit noisy);
        a         = ta;
        b         = tb_v;
        borrow_in = tbin;
        start     = 1'b1;
        tick();
        start = noisy;
        for (int i = 0; i < int'(W); i++) begin
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_done", 32'(done), 32'd0);
            chk_held("shift_hold");
            a         = W'($urandom);
            b         = W'($urandom);
            borrow_in = 1'($urandom);
            tick();
        end
        model(ta, tb_v, tbin);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk_held("done");
        tick();
        start = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk_held("idle");
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        exp_diff  = '0;
        exp_bout  = 1'b0;
        exp_ovf   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_held("rst");
        reset = 1'b0;
        tick();

        do_op(4'd9, 4'd3, 1'b0, 1'b0);
        do_op(4'd3, 4'd9, 1'b0, 1'b0);
        chk("t2_diff_abs", 32'(diff), 32'hA);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_busy", 32'(busy), 32'd0);
            chk_held("hold10");
        end
        do_op(4'd0, 4'd0, 1'b1, 1'b0);
        chk("t3_diff_abs", 32'(diff), 32'hF);

        // Start held high through SHIFT and DONE is ignored; the next IDLE start is taken.
        do_op(4'd12, 4'd5, 1'b1, 1'b1);
        chk("t4_diff_abs", 32'(diff), 32'd6);
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        do_op(4'd2, 4'd7, 1'b0, 1'b0);

        // Reset during the second SHIFT cycle aborts the operation.
        a         = 4'd15;
        b         = 4'd1;
        borrow_in = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rst2_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);
        chk_held("rst2");
        for (int i = 0; i < int'(W) + 2; i++) begin
            tick();
            chk("rst2_nodone", 32'(done), 32'd0);
            chk("rst2_nobusy", 32'(busy), 32'd0);
        end
        do_op(4'd15, 4'd1, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        do_op(4'd8, 4'd1, 1'b0, 1'b0);
        chk("ovf_8m1_diff", 32'(diff), 32'd7);
        chk("ovf_8m1_flag", 32'(ovf), 32'd1);
        do_op(4'd5, 4'd2, 1'b0, 1'b0);
        chk("ovf_5m2_diff", 32'(diff), 32'd3);
        chk("ovf_5m2_flag", 32'(ovf), 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule : tb_serial_subtractor
